iob_pcie_tx_arbiter: RTL and testbench
======================================

Name: iob_pcie_tx_arbiter

Overview:
- Shares the single PCIe TX channel between N_REQ on-chip requesters: DMA engine, CSR readback path and similar.
- Round-robin arbitration across requesters.
- Sequences the channel protocol per transaction: request → ack wait → data stream → release.
- Sits between the requesters and the TX side of the PCIe channel core, in the core clock domain.

Parameters:
N_REQ, 2, number of requesters (2..8)
DATA_W, 32, channel data width
ACK_TIMEOUT, 1024, cycles to wait for TX ack before aborting (≥2)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
req_valid  in  N_REQ  per-requester transfer request; held until req_grant
req_len  in  N_REQ*32  per-requester transfer length in DATA_W words
req_last  in  N_REQ  per-requester "last transaction" flag
req_data  in  N_REQ*DATA_W  per-requester data
req_data_valid  in  N_REQ  per-requester data valid
req_data_ren  out  N_REQ  per-requester data accept (only granted bit may be 1)
req_grant  out  N_REQ  one-hot grant, high from ACK_WAIT through DONE
req_done  out  N_REQ  one-cycle completion pulse to granted requester
chnl_tx  out  1  channel transaction request
chnl_tx_ack  in  1  channel acknowledge
chnl_tx_last  out  1  latched req_last of winner
chnl_tx_len  out  32  latched req_len of winner
chnl_tx_off  out  31  constant 0
chnl_tx_data  out  DATA_W  data of granted requester
chnl_tx_data_valid  out  1  valid of granted requester, gated to XFER
chnl_tx_data_ren  in  1  channel data accept
timeout_err  out  1  sticky ack-timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
Reset:
- While rst=0: state=IDLE; rr_ptr=0; all outputs 0, including timeout_err.
- Reset mid-transaction aborts immediately.
- No done pulse is issued for the aborted transaction.

FSM states: IDLE, ACK_WAIT, XFER, DONE.

IDLE:
- If any req_valid, select the winner by round-robin: first set bit scanning from rr_ptr upward, wrapping modulo N_REQ.
- Latch the winner index, req_len and req_last.
- Next cycle: state=ACK_WAIT, chnl_tx=1, req_grant[winner]=1.
- Latency from req_valid rising to chnl_tx=1: 1 cycle.

ACK_WAIT:
- chnl_tx held 1; ack timer counts.
- On chnl_tx_ack=1: next state is XFER, or DONE if latched len=0. Word counter cleared.
- If the timer reaches ACK_TIMEOUT-1 without ack:
  - chnl_tx drops next cycle; timeout_err=1; state=IDLE.
  - No req_done pulse.
  - rr_ptr=winner+1.
- If ack and timeout occur in the same cycle, ack wins.

XFER:
- chnl_tx held 1.
- Data path is combinational pass-through from the granted requester:
  - chnl_tx_data = req_data[winner]
  - chnl_tx_data_valid = req_data_valid[winner]
  - req_data_ren[winner] = chnl_tx_data_ren
- A word transfers when valid & ren are both high; the counter increments on each transfer.
- When a transfer makes the count equal len: next state is DONE.

DONE (1 cycle):
- chnl_tx=0; req_done[winner]=1; req_grant drops next cycle.
- rr_ptr=winner+1 mod N_REQ.
- Next state: IDLE.
- Minimum gap between transactions is 1 IDLE cycle.

Arbitration and latching:
- req_valid changes after grant are ignored.
- req_len and req_last changes after latch are ignored.
- Non-granted requesters see req_data_ren=0.
- chnl_tx_len and chnl_tx_last hold their latched values from ACK_WAIT through DONE, and are 0 in IDLE.

Counter widths:
- Word counter is 32 bit; len up to 2^32-1.
- Timer is clog2(ACK_TIMEOUT) bits.

timeout_err:
- Set by a timeout; cleared by err_clr.
- Set has priority when set and err_clr coincide.

Test Plan:
- Single request: req_valid[0]=1, len=4, ack 3 cycles later, ren always 1, data 0xA0..0xA3 → chnl_tx high 1 cycle after request; 4 words out in order; req_done[0] pulses once; chnl_tx=0 in DONE.
- Round-robin: req_valid=2'b11 held, len=2 each → grants alternate 0,1,0,1; each grant followed by exactly 2 transfers.
- Backpressure: len=3, chnl_tx_data_ren toggling 1,0,1,0, requester valid gaps → exactly 3 transfers counted; req_data_ren mirrors ren only for the granted requester.
- Zero length: len=0, ack → DONE directly after ack; no chnl_tx_data_valid asserted; req_done pulse.
- Timeout: ACK_TIMEOUT=16, ack never asserted → chnl_tx drops after 16 cycles; timeout_err=1; next pending requester granted; err_clr clears flag.
- Reset mid-XFER: rst=0 after 2 of 8 words → all outputs 0 asynchronously; after release, FSM is IDLE and rr_ptr=0.

Source files
------------

// File: rtl/iob_pcie_tx_arbiter.sv
// Round-robin arbiter sharing one PCIe TX channel between N_REQ requesters.
// Each grant runs request -> ack wait -> data stream -> release, with an ack timeout.
module iob_pcie_tx_arbiter #(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*32-1:0]     req_len,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_data_valid,
  output logic [N_REQ-1:0]        req_data_ren,
  output logic [N_REQ-1:0]        req_grant,
  output logic [N_REQ-1:0]        req_done,
  output logic                    chnl_tx,
  input  logic                    chnl_tx_ack,
  output logic                    chnl_tx_last,
  output logic [31:0]             chnl_tx_len,
  output logic [30:0]             chnl_tx_off,
  output logic [DATA_W-1:0]       chnl_tx_data,
  output logic                    chnl_tx_data_valid,
  input  logic                    chnl_tx_data_ren,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMR_W = $clog2(ACK_TIMEOUT);
  localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W+1)'(N_REQ);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACK_WAIT, XFER, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  winner_next;
  logic [TMR_W-1:0]  timer;
  logic [31:0]       word_cnt;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W:0]    cand_sum;
  logic [IDX_W-1:0]  cand;
  logic [31:0]       pick_len;
  logic              pick_last;
  logic [DATA_W-1:0] win_data;
  logic              win_valid;
  logic              in_xfer;
  logic              xfer_beat;
  logic              timer_hit;

  // Scan from rr_ptr upward, wrapping, and take the first requester asking.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand_sum >= N_REQ_W) cand_sum = cand_sum - N_REQ_W;
      cand = cand_sum[IDX_W-1:0];
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_len  = '0;
    pick_last = 1'b0;
    win_data  = '0;
    win_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_len  = req_len[i*32 +: 32];
        pick_last = req_last[i];
      end
      if (winner == IDX_W'(i)) begin
        win_data  = req_data[i*DATA_W +: DATA_W];
        win_valid = req_data_valid[i];
      end
    end
  end

  assign in_xfer            = (state == XFER);
  assign chnl_tx_data       = in_xfer ? win_data : '0;
  assign chnl_tx_data_valid = in_xfer & win_valid;
  assign xfer_beat          = chnl_tx_data_valid & chnl_tx_data_ren;
  assign chnl_tx_off        = '0;
  assign timer_hit          = (timer == TMR_LAST);
  assign winner_next        = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);

  always_comb begin
    req_data_ren = '0;
    for (int i = 0; i < N_REQ; i++)
      req_data_ren[i] = in_xfer && chnl_tx_data_ren && (winner == IDX_W'(i));
  end

  // Ack in the same cycle as the timeout expiry wins; a timeout releases without req_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      winner       <= '0;
      timer        <= '0;
      word_cnt     <= '0;
      chnl_tx      <= 1'b0;
      chnl_tx_len  <= '0;
      chnl_tx_last <= 1'b0;
      req_grant    <= '0;
      req_done     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            winner       <= pick_idx;
            chnl_tx_len  <= pick_len;
            chnl_tx_last <= pick_last;
            chnl_tx      <= 1'b1;
            req_grant    <= N_REQ'(1) << pick_idx;
            timer        <= '0;
            state        <= ACK_WAIT;
          end
        end
        ACK_WAIT: begin
          if (chnl_tx_ack) begin
            word_cnt <= '0;
            if (chnl_tx_len == '0) begin
              state    <= DONE;
              chnl_tx  <= 1'b0;
              req_done <= req_grant;
            end else begin
              state <= XFER;
            end
          end else if (timer_hit) begin
            state        <= IDLE;
            chnl_tx      <= 1'b0;
            req_grant    <= '0;
            chnl_tx_len  <= '0;
            chnl_tx_last <= 1'b0;
            timeout_err  <= 1'b1;
            rr_ptr       <= winner_next;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        XFER: begin
          if (xfer_beat) begin
            word_cnt <= word_cnt + 32'd1;
            if (word_cnt + 32'd1 == chnl_tx_len) begin
              state    <= DONE;
              chnl_tx  <= 1'b0;
              req_done <= req_grant;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          req_done     <= '0;
          req_grant    <= '0;
          chnl_tx_len  <= '0;
          chnl_tx_last <= 1'b0;
          rr_ptr       <= winner_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_pcie_tx_arbiter.sv
// Self-checking bench for iob_pcie_tx_arbiter: vector table, directed corner
// sequences, and randomized traffic checked against a transaction-level model.
module tb_iob_pcie_tx_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int NT = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_len;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_data_valid;
  logic [N-1:0]    req_data_ren;
  logic [N-1:0]    req_grant;
  logic [N-1:0]    req_done;
  logic            chnl_tx;
  logic            chnl_tx_ack;
  logic            chnl_tx_last;
  logic [31:0]     chnl_tx_len;
  logic [30:0]     chnl_tx_off;
  logic [DW-1:0]   chnl_tx_data;
  logic            chnl_tx_data_valid;
  logic            chnl_tx_data_ren;
  logic            timeout_err;
  logic            err_clr;

  int compared   = 0;
  int mismatched = 0;

  iob_pcie_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_len(req_len), .req_last(req_last),
    .req_data(req_data), .req_data_valid(req_data_valid),
    .req_data_ren(req_data_ren), .req_grant(req_grant), .req_done(req_done),
    .chnl_tx(chnl_tx), .chnl_tx_ack(chnl_tx_ack), .chnl_tx_last(chnl_tx_last),
    .chnl_tx_len(chnl_tx_len), .chnl_tx_off(chnl_tx_off),
    .chnl_tx_data(chnl_tx_data), .chnl_tx_data_valid(chnl_tx_data_valid),
    .chnl_tx_data_ren(chnl_tx_data_ren),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  valid;
    logic [31:0]   len;
    logic          last;
    logic          ack;
    logic          ren;
    logic [N-1:0]  dv;
    logic [DW-1:0] data;
    logic          exp_tx;
    logic [N-1:0]  exp_grant;
    logic [N-1:0]  exp_done;
    logic          exp_dv;
    logic [31:0]   exp_len;
    logic          exp_last;
    logic [N-1:0]  exp_ren;
  } vec_t;

  vec_t tbl[14];

  int          tlen[N][NT];
  logic        tlast[N][NT];
  logic [31:0] salt[N][NT];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {20'd0, chnl_tx, req_grant, req_done, chnl_tx_data_valid,
            chnl_tx_len, chnl_tx_last, req_data_ren};
  endfunction

  function automatic logic [63:0] exp_vec(input vec_t v);
    return {20'd0, v.exp_tx, v.exp_grant, v.exp_done, v.exp_dv,
            v.exp_len, v.exp_last, v.exp_ren};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] word_of(input int r, input int t, input int w);
    return salt[r][t] + DW'(w);
  endfunction

  task automatic clear_inputs();
    req_valid = '0; req_len = '0; req_last = '0; req_data = '0;
    req_data_valid = '0; chnl_tx_ack = 1'b0; chnl_tx_data_ren = 1'b0; err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    checkOutput(tag, out_vec(), 64'd0);
    checkOutput({tag, "_data"}, 64'(chnl_tx_data), 64'd0);
    checkOutput({tag, "_err"}, 64'(timeout_err), 64'd0);
    checkOutput({tag, "_off"}, 64'(chnl_tx_off), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_idle_zero(tag);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid        = v.valid;
    req_len          = {N{v.len}};
    req_last         = {N{v.last}};
    chnl_tx_ack      = v.ack;
    chnl_tx_data_ren = v.ren;
    req_data_valid   = v.dv;
    req_data         = {N{v.data}};
  endtask

  task automatic run_txn(input int r, input int len, input int stop_at,
                         output int beats, output bit done_seen);
    bit granted;
    granted   = 1'b0;
    beats     = 0;
    done_seen = 1'b0;
    req_len[r*32 +: 32] = 32'(len);
    chnl_tx_data_ren = 1'b1;
    req_data_valid   = '1;
    for (int c = 0; c < 100; c++) begin
      req_valid = granted ? '0 : N'(1) << r;
      req_data[r*DW +: DW] = 32'hC000_0000 + DW'(beats);
      chnl_tx_ack = chnl_tx;
      @(negedge clk);
      if (req_grant[r]) granted = 1'b1;
      if (chnl_tx_data_valid && chnl_tx_data_ren) beats++;
      if (req_done[r]) begin
        done_seen = 1'b1;
        tick();
        return;
      end
      if (stop_at > 0 && beats == stop_at) begin
        @(posedge clk);
        #2;
        return;
      end
      tick();
    end
  endtask

  int            beats, hi, done_cnt, completed, cur_win, model_ptr, wait_cnt, ack_delay;
  bit            done_seen, in_xfer, acked, gap_chk;
  logic [N-1:0]  grants[$];
  logic [N-1:0]  prev_valid, prev_grant;
  int            cur[N];
  bit            want[N];

  initial begin
    clear_inputs();

    // ---------------- table: single request len=4, then zero-length ----------------
    tbl[0]  = '{3'b001, 32'd4, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'b000};
    tbl[1]  = '{3'b000, 32'd4, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0,  1'b1, 3'b001, 3'b000, 1'b0, 32'd4, 1'b1, 3'b000};
    tbl[2]  = '{3'b000, 32'd4, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0,  1'b1, 3'b001, 3'b000, 1'b0, 32'd4, 1'b1, 3'b000};
    tbl[3]  = '{3'b000, 32'd4, 1'b1, 1'b1, 1'b1, 3'b000, 32'h0,  1'b1, 3'b001, 3'b000, 1'b0, 32'd4, 1'b1, 3'b000};
    tbl[4]  = '{3'b000, 32'd4, 1'b1, 1'b0, 1'b1, 3'b001, 32'hA0, 1'b1, 3'b001, 3'b000, 1'b1, 32'd4, 1'b1, 3'b001};
    tbl[5]  = '{3'b000, 32'd4, 1'b1, 1'b0, 1'b1, 3'b001, 32'hA1, 1'b1, 3'b001, 3'b000, 1'b1, 32'd4, 1'b1, 3'b001};
    tbl[6]  = '{3'b000, 32'd4, 1'b1, 1'b0, 1'b1, 3'b001, 32'hA2, 1'b1, 3'b001, 3'b000, 1'b1, 32'd4, 1'b1, 3'b001};
    tbl[7]  = '{3'b000, 32'd4, 1'b1, 1'b0, 1'b1, 3'b001, 32'hA3, 1'b1, 3'b001, 3'b000, 1'b1, 32'd4, 1'b1, 3'b001};
    tbl[8]  = '{3'b000, 32'd4, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0, 3'b001, 3'b001, 1'b0, 32'd4, 1'b1, 3'b000};
    tbl[9]  = '{3'b000, 32'd4, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'b000};
    tbl[10] = '{3'b010, 32'd0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'b000};
    tbl[11] = '{3'b000, 32'd0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0,  1'b1, 3'b010, 3'b000, 1'b0, 32'd0, 1'b0, 3'b000};
    tbl[12] = '{3'b000, 32'd0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h55, 1'b0, 3'b010, 3'b010, 1'b0, 32'd0, 1'b0, 3'b000};
    tbl[13] = '{3'b000, 32'd0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,  1'b0, 3'b000, 3'b000, 1'b0, 32'd0, 1'b0, 3'b000};

    do_reset("reset_state");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), out_vec(), exp_vec(tbl[i]));
      if (tbl[i].exp_dv) checkOutput($sformatf("vec%0d_data", i), 64'(chnl_tx_data), 64'(tbl[i].data));
      tick();
    end

    // ---------------- round-robin: both held, len=2 ----------------
    do_reset("rr_reset");
    req_valid = 3'b011;
    req_len = {N{32'd2}};
    req_data_valid = '1;
    chnl_tx_data_ren = 1'b1;
    grants.delete();
    prev_grant = '0; beats = 0; done_cnt = 0; gap_chk = 1'b0;
    for (int c = 0; c < 200 && done_cnt < 4; c++) begin
      chnl_tx_ack = chnl_tx;
      @(negedge clk);
      if (gap_chk) begin
        checkOutput("rr_gap", 64'(req_grant), 64'd0);
        gap_chk = 1'b0;
      end
      if (req_grant != '0 && prev_grant == '0) grants.push_back(req_grant);
      if (chnl_tx_data_valid && chnl_tx_data_ren) beats++;
      if (req_done != '0) begin
        checkOutput($sformatf("rr_beats%0d", done_cnt), 64'(beats), 64'd2);
        beats = 0; done_cnt++; gap_chk = 1'b1;
      end
      prev_grant = req_grant;
      tick();
    end
    checkOutput("rr_dones", 64'(done_cnt), 64'd4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      checkOutput($sformatf("rr_grant%0d", k), 64'(grants[k]), (k % 2 == 0) ? 64'd1 : 64'd2);

    // ---------------- backpressure: len=3, ren toggling, valid gaps ----------------
    do_reset("bp_reset");
    req_len[31:0] = 32'd3;
    beats = 0; done_seen = 1'b0; in_xfer = 1'b0;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      req_valid[0]      = (req_grant == '0) && (c < 2);
      chnl_tx_data_ren  = (c % 2 == 0);
      req_data_valid[0] = (c % 3 != 2);
      req_data_valid[1] = 1'b1;
      req_data[DW-1:0]  = 32'hB0 + DW'(beats);
      req_data[2*DW-1:DW] = 32'hDEAD_BEEF;
      chnl_tx_ack = chnl_tx;
      @(negedge clk);
      checkOutput($sformatf("bp_ren_c%0d", c), 64'(req_data_ren),
                  in_xfer ? 64'(chnl_tx_data_ren) : 64'd0);
      if (chnl_tx_data_valid && chnl_tx_data_ren) begin
        checkOutput($sformatf("bp_word%0d", beats), 64'(chnl_tx_data), 64'(32'hB0 + beats));
        beats++;
      end
      if (req_done[0]) begin
        done_seen = 1'b1;
        in_xfer = 1'b0;
      end else if (chnl_tx && chnl_tx_ack) begin
        in_xfer = 1'b1;
      end
      tick();
    end
    checkOutput("bp_done", 64'(done_seen), 64'd1);
    checkOutput("bp_beats", 64'(beats), 64'd3);

    // ---------------- ack timeout, then next requester, then err_clr ----------------
    do_reset("tmo_reset");
    req_len = '0;
    req_valid = 3'b011;
    @(negedge clk);
    checkOutput("tmo_idle", 64'(req_grant), 64'd0);
    tick();
    req_valid = 3'b010;
    hi = 0; done_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!chnl_tx) break;
      if (req_done != '0) done_seen = 1'b1;
      hi++;
      tick();
    end
    checkOutput("tmo_tx_cycles", 64'(hi), 64'd16);
    checkOutput("tmo_no_done", 64'(done_seen), 64'd0);
    checkOutput("tmo_err_set", 64'(timeout_err), 64'd1);
    checkOutput("tmo_grant_drop", 64'(req_grant), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("tmo_next_grant", 64'(req_grant), 64'd2);
    tick();
    chnl_tx_ack = 1'b1;
    @(negedge clk);
    tick();
    chnl_tx_ack = 1'b0;
    @(negedge clk);
    checkOutput("tmo_next_done", 64'(req_done), 64'd2);
    checkOutput("tmo_err_sticky", 64'(timeout_err), 64'd1);
    tick();
    err_clr = 1'b1;
    @(negedge clk);
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("tmo_err_clr", 64'(timeout_err), 64'd0);
    tick();

    // ---------------- reset in the middle of a transfer ----------------
    do_reset("mid_reset");
    run_txn(0, 1, 0, beats, done_seen);
    checkOutput("mid_first_done", 64'(done_seen), 64'd1);
    run_txn(1, 8, 2, beats, done_seen);
    checkOutput("mid_beats", 64'(beats), 64'd2);
    checkOutput("mid_active", 64'(chnl_tx), 64'd1);
    rst = 1'b0;
    #1;
    check_idle_zero("mid_async");
    @(negedge clk);
    check_idle_zero("mid_hold");
    rst = 1'b1;
    tick();
    req_valid = 3'b011;
    chnl_tx_ack = 1'b0;
    @(negedge clk);
    checkOutput("mid_idle", out_vec(), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("mid_rrptr", 64'(req_grant), 64'd1);

    // ---------------- randomized traffic vs transaction-level model ----------------
    for (int r = 0; r < N; r++) begin
      for (int t = 0; t < NT; t++) begin
        tlen[r][t]  = int'($urandom_range(0, 5));
        tlast[r][t] = 1'($urandom_range(0, 1));
        salt[r][t]  = $urandom;
      end
      cur[r]  = 0;
      want[r] = 1'b1;
    end
    do_reset("rnd_reset");
    model_ptr = 0; completed = 0; cur_win = -1; beats = 0;
    acked = 1'b1; wait_cnt = 0; ack_delay = 0;
    prev_valid = '0; prev_grant = '0;
    for (int c = 0; c < 20000 && completed < N*NT; c++) begin
      for (int r = 0; r < N; r++) begin
        int t;
        t = (cur[r] < NT) ? cur[r] : NT - 1;
        req_valid[r]          = want[r];
        req_len[r*32 +: 32]   = 32'(tlen[r][t]);
        req_last[r]           = tlast[r][t];
        req_data[r*DW +: DW]  = word_of(r, t, (r == cur_win) ? beats : 0);
        req_data_valid[r]     = ($urandom_range(0, 3) != 0);
      end
      chnl_tx_data_ren = ($urandom_range(0, 3) != 0);
      chnl_tx_ack = chnl_tx && !acked && (wait_cnt >= ack_delay);
      @(negedge clk);
      checkOutput("rnd_ren_isolation", 64'(req_data_ren & ~req_grant), 64'd0);
      if (req_grant != '0 && prev_grant == '0) begin
        cur_win = rr_pick(prev_valid, model_ptr);
        if (cur_win < 0) begin
          checkOutput("rnd_spurious_grant", 64'(req_grant), 64'd0);
        end else begin
          checkOutput("rnd_grant", 64'(req_grant), 64'(1) << cur_win);
          checkOutput("rnd_len", 64'(chnl_tx_len), 64'(tlen[cur_win][cur[cur_win]]));
          checkOutput("rnd_last", 64'(chnl_tx_last), 64'(tlast[cur_win][cur[cur_win]]));
          want[cur_win] = 1'b0;
        end
        beats = 0; acked = 1'b0; wait_cnt = 0;
        ack_delay = int'($urandom_range(0, 6));
      end
      if (chnl_tx_data_valid && chnl_tx_data_ren && cur_win >= 0) begin
        checkOutput("rnd_data", 64'(chnl_tx_data), 64'(word_of(cur_win, cur[cur_win], beats)));
        beats++;
      end
      if (chnl_tx && !acked) begin
        if (chnl_tx_ack) acked = 1'b1;
        else wait_cnt++;
      end
      if (req_done != '0) begin
        if (cur_win < 0) begin
          checkOutput("rnd_spurious_done", 64'(req_done), 64'd0);
        end else begin
          checkOutput("rnd_done", 64'(req_done), 64'(1) << cur_win);
          checkOutput("rnd_beats", 64'(beats), 64'(tlen[cur_win][cur[cur_win]]));
          model_ptr = (cur_win + 1) % N;
          cur[cur_win]++;
          want[cur_win] = (cur[cur_win] < NT);
          completed++;
          cur_win = -1;
        end
      end
      prev_valid = req_valid;
      prev_grant = req_grant;
      tick();
    end
    checkOutput("rnd_completed", 64'(completed), 64'(N*NT));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
